data_mem_responder: RTL and testbench

Memory-side responder for the core's data port. It accepts one load or store per request, holds it for a programmable number of wait cycles, and then completes it with a one-cycle acknowledge. It sits between the data-port pins (`daddr`, `ddata_w`, `WRam`, `ddata_r`) and a word-addressed RAM. Two top-of-space words are mapped to peripherals: an LED register and a free-running cycle counter.

---
 rtl/data_mem_pkg.sv | 7 +
 rtl/mem_array.sv | 19 +
 rtl/data_mem_responder.sv | 88 ++++++++
 tb/tb_data_mem_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: state encoding and address-map constants shared by data_mem_responder
package data_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int CNT_OFS = 2;
  localparam int LED_OFS = 1;
  localparam int WCNT_W = 4;
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM with write enable and registered read port
module mem_array #(
  parameter int DEPTH = 1022,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-port responder with programmable latency, RAM, LED register and cycle counter
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int N = 1024,
  parameter int LATENCY = 2,
  localparam int n = $clog2(N)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         req,
  input  logic         WRam,
  input  logic [n-1:0] daddr,
  input  logic [31:0]  ddata_w,
  output logic [31:0]  ddata_r,
  output logic         ack,
  output logic         busy,
  output logic [7:0]   leds
);
  state_t state, nxt;
  logic [WCNT_W-1:0] wcnt;
  logic [n-1:0] addr_q, cur_addr;
  logic [31:0] data_q, cur_data, hold, cnt, ram_q;
  logic we_q, cur_we, rd_ram, enter, is_cnt, is_led, is_ram;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("LATENCY must be in 1..15");
  end

  // With LATENCY=1 the accept edge is also the edge entering RESP, so decode works on the live inputs in IDLE
  always_comb begin
    nxt = state == IDLE ? (req ? (LATENCY == 1 ? RESP : WAIT) : IDLE)
        : state == WAIT ? (wcnt == WCNT_W'(1) ? RESP : WAIT) : IDLE;
    cur_addr = state == IDLE ? daddr : addr_q;
    cur_data = state == IDLE ? ddata_w : data_q;
    cur_we = state == IDLE ? WRam : we_q;
    enter = nxt == RESP;
    is_cnt = cur_addr == n'(N - CNT_OFS);
    is_led = cur_addr == n'(N - LED_OFS);
    is_ram = !is_cnt && !is_led;
  end

  mem_array #(.DEPTH(N - CNT_OFS), .AW(n)) u_mem (
    .clk(CLK),
    .en(enter && is_ram),
    .we(enter && is_ram && cur_we),
    .addr(cur_addr),
    .wdata(cur_data),
    .rdata(ram_q)
  );

  // RAM load data is shown straight from the RAM output during RESP, then parked in hold
  assign ddata_r = rd_ram ? ram_q : hold;

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      wcnt <= '0;
      ack <= 1'b0;
      busy <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      we_q <= 1'b0;
      hold <= '0;
      rd_ram <= 1'b0;
      leds <= '0;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt + 32'd1;
      ack <= nxt == RESP;
      busy <= nxt != IDLE;
      if (state == IDLE && req) begin
        addr_q <= daddr;
        data_q <= ddata_w;
        we_q <= WRam;
        wcnt <= WCNT_W'(LATENCY - 1);
      end else if (state == WAIT) wcnt <= wcnt - WCNT_W'(1);
      if (enter && cur_we && is_led) leds <= cur_data[7:0];
      if (enter && !cur_we) begin
        rd_ram <= is_ram;
        if (!is_ram) hold <= is_cnt ? cnt : {24'b0, leds};
      end else if (rd_ram) begin
        rd_ram <= 1'b0;
        hold <= ram_q;
      end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: LATENCY=2 and LATENCY=1 builds driven in parallel, checked against a timestamp model
module tb_data_mem_responder;
  localparam int N = 1024;
  localparam int AW = $clog2(N);

  logic clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0;
  logic [AW-1:0] daddr = '0;
  logic [31:0] wdata = '0;
  logic [1:0] ack_v, busy_v;
  logic [31:0] rd_v [2];
  logic [7:0] led_v [2];
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.N(N), .LATENCY(2)) u_dut2 (
    .CLK(clk), .RST(rst), .req(req), .WRam(we), .daddr(daddr), .ddata_w(wdata),
    .ddata_r(rd_v[0]), .ack(ack_v[0]), .busy(busy_v[0]), .leds(led_v[0])
  );
  data_mem_responder #(.N(N), .LATENCY(1)) u_dut1 (
    .CLK(clk), .RST(rst), .req(req), .WRam(we), .daddr(daddr), .ddata_w(wdata),
    .ddata_r(rd_v[1]), .ack(ack_v[1]), .busy(busy_v[1]), .leds(led_v[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lt(input int k);
    return k == 0 ? 2 : 1;
  endfunction

  // Model: each build remembers when its transaction was accepted; everything follows from that timestamp
  int cyc = 0;
  logic [31:0] m_cnt = '0;
  bit m_has [2] = '{0, 0};
  int m_acc [2] = '{0, 0};
  bit m_we [2];
  int m_addr [2];
  logic [31:0] m_data [2];
  logic [31:0] e_d [2] = '{32'h0, 32'h0};
  bit e_known [2] = '{1, 1};
  logic [7:0] e_led [2] = '{8'h0, 8'h0};
  bit e_ack [2] = '{0, 0};
  bit e_busy [2] = '{0, 0};
  logic [31:0] mmem [int];

  task automatic model_step();
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        if (m_has[k] && cyc == m_acc[k] + lt(k) && m_we[k] && m_addr[k] < N - 2)
          mmem.delete(k * 2048 + m_addr[k]);
        m_has[k] = 0; e_ack[k] = 0; e_busy[k] = 0;
        e_led[k] = '0; e_d[k] = '0; e_known[k] = 1;
      end
      m_cnt = '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit busy_now;
        busy_now = m_has[k] && m_acc[k] < cyc && cyc <= m_acc[k] + lt(k);
        if (!busy_now && req) begin
          m_has[k] = 1; m_acc[k] = cyc; m_we[k] = we;
          m_addr[k] = int'(daddr); m_data[k] = wdata;
        end
        if (m_has[k] && cyc == m_acc[k] + lt(k) - 1) begin
          if (m_we[k]) begin
            if (m_addr[k] == N - 1) e_led[k] = m_data[k][7:0];
            else if (m_addr[k] < N - 2) mmem[k * 2048 + m_addr[k]] = m_data[k];
          end else if (m_addr[k] == N - 2) begin
            e_d[k] = m_cnt; e_known[k] = 1;
          end else if (m_addr[k] == N - 1) begin
            e_d[k] = {24'b0, e_led[k]}; e_known[k] = 1;
          end else begin
            e_known[k] = mmem.exists(k * 2048 + m_addr[k]) != 0;
            if (e_known[k]) e_d[k] = mmem[k * 2048 + m_addr[k]];
          end
        end
        e_ack[k] = m_has[k] && cyc + 1 == m_acc[k] + lt(k);
        e_busy[k] = m_has[k] && m_acc[k] < cyc + 1 && cyc + 1 <= m_acc[k] + lt(k);
      end
      m_cnt = m_cnt + 32'd1;
      cyc++;
    end
  endtask

  always @(posedge clk or posedge rst) model_step();

  always @(negedge clk)
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ack[L=%0d]", lt(k)), 32'(ack_v[k]), 32'(e_ack[k]));
      chk($sformatf("busy[L=%0d]", lt(k)), 32'(busy_v[k]), 32'(e_busy[k]));
      chk($sformatf("leds[L=%0d]", lt(k)), 32'(led_v[k]), 32'(e_led[k]));
      if (e_known[k]) chk($sformatf("ddata_r[L=%0d]", lt(k)), rd_v[k], e_d[k]);
    end

  task automatic txn(input logic w, input int a, input logic [31:0] d,
                     output int l0, output int l1, output logic [31:0] q0, output logic [31:0] q1);
    l0 = -1; l1 = -1; q0 = '0; q1 = '0;
    req = 1'b1; we = w; daddr = AW'(a); wdata = d;
    @(negedge clk);
    req = 1'b0;
    for (int i = 1; i <= 20 && (l0 < 0 || l1 < 0); i++) begin
      if (ack_v[0] && l0 < 0) begin l0 = i; q0 = rd_v[0]; end
      if (ack_v[1] && l1 < 0) begin l1 = i; q1 = rd_v[1]; end
      if (l0 < 0 || l1 < 0) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    int l0, l1, n0, n1;
    logic [31:0] q0, q1;
    logic [31:0] cv [2];
    cv[0] = '0; cv[1] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ddata_r", rd_v[0], 32'h0);
    chk("rst_busy", 32'(busy_v[0]), 32'h0);
    chk("rst_leds", 32'(led_v[0]), 32'h0);
    #2 rst = 1'b0;
    @(negedge clk);

    txn(1'b1, 5, 32'hDEADBEEF, l0, l1, q0, q1);
    chk("st5_lat2", l0, 2);
    chk("st5_lat1", l1, 1);
    txn(1'b0, 5, 32'h0, l0, l1, q0, q1);
    chk("ld5_lat2", l0, 2);
    chk("ld5_data2", q0, 32'hDEADBEEF);
    chk("ld5_data1", q1, 32'hDEADBEEF);

    req = 1'b1; we = 1'b0; daddr = AW'(N - 2); n0 = 0;
    for (int i = 0; i < 12 && n0 < 2; i++) begin
      @(negedge clk);
      if (ack_v[0]) begin cv[n0] = rd_v[0]; n0++; end
    end
    req = 1'b0;
    repeat (2) @(negedge clk);
    chk("cnt_acks", n0, 2);
    chk("cnt_diff", cv[1] - cv[0], 32'd3);

    txn(1'b1, N - 1, 32'h12345678, l0, l1, q0, q1);
    chk("led_val", 32'(led_v[0]), 32'h78);
    txn(1'b0, N - 1, 32'h0, l0, l1, q0, q1);
    chk("led_load", q0, 32'h00000078);
    txn(1'b1, N - 2, 32'hFFFFFFFF, l0, l1, q0, q1);
    chk("cnt_store_lat", l0, 2);
    txn(1'b0, N - 2, 32'h0, l0, l1, q0, q1);
    chk("cnt_unchanged", 32'(q0 < 32'd1000), 32'd1);

    req = 1'b1; we = 1'b1; daddr = AW'(20); wdata = 32'd20; n0 = 0; n1 = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n0 += int'(ack_v[0]);
      n1 += int'(ack_v[1]);
      if (i < 6) begin daddr = AW'(20 + i); wdata = 32'(20 + i); end
      else req = 1'b0;
    end
    chk("hold_acks_L2", n0, 2);
    chk("hold_acks_L1", n1, 3);
    txn(1'b0, 23, 32'h0, l0, l1, q0, q1);
    chk("hold_ld23_L2", q0, 32'd23);
    txn(1'b0, 22, 32'h0, l0, l1, q0, q1);
    chk("hold_ld22_L1", q1, 32'd22);

    txn(1'b1, 0, 32'hCAFEF00D, l0, l1, q0, q1);
    chk("l1_st_lat", l1, 1);
    txn(1'b0, 0, 32'h0, l0, l1, q0, q1);
    chk("l1_ld_lat", l1, 1);
    chk("l1_ld_data", q1, 32'hCAFEF00D);

    txn(1'b1, 9, 32'hA5A5A5A5, l0, l1, q0, q1);
    req = 1'b1; we = 1'b1; daddr = AW'(9); wdata = 32'h11111111;
    @(negedge clk);
    req = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rstmid_ack", 32'(ack_v[0]), 32'h0);
    chk("rstmid_busy", 32'(busy_v[0]), 32'h0);
    chk("rstmid_ddata_r", rd_v[0], 32'h0);
    chk("rstmid_leds", 32'(led_v[0]), 32'h0);
    n0 = 0;
    repeat (3) begin
      @(negedge clk);
      n0 += int'(ack_v[0]);
    end
    chk("rstmid_noack", n0, 0);
    #2 rst = 1'b0;
    txn(1'b0, 9, 32'h0, l0, l1, q0, q1);
    chk("rstmid_ld9", q0, 32'hA5A5A5A5);

    repeat (400) begin
      req = ($urandom % 3) != 0;
      we = 1'($urandom % 2);
      case ($urandom % 8)
        6: daddr = AW'(N - 2);
        7: daddr = AW'(N - 1);
        default: daddr = AW'($urandom % 16);
      endcase
      wdata = $urandom;
      @(negedge clk);
    end
    req = 1'b0;
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
